// File: rtl/rca_nibble_seq.sv
// rca_nibble_seq: nibble-serial adder, one 4-bit slice per clock, LSB first.
// Define ADD_SUB_EN to honour the sub port (A-B); otherwise every operation is A+B+cin.
module rca_nibble_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);
   localparam int N  = WIDTH / 4;
   localparam int IW = $clog2(N);
`ifdef ADD_SUB_EN
   localparam logic SUB_EN = 1'b1;
`else
   localparam logic SUB_EN = 1'b0;
`endif
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_d;
   logic [WIDTH-1:0] a_r, b_r;
   logic             carry_r;
   logic [IW-1:0]    idx;
   logic [4:0]       slice;
   logic             last, accept, do_sub;
   assign do_sub    = sub & SUB_EN;
   assign accept    = state == IDLE && in_valid;
   assign last      = idx == IW'(N - 1);
   // {idx,2'b00} is exactly $clog2(WIDTH) bits wide since WIDTH = 4*N
   assign slice     = {1'b0, a_r[{idx, 2'b00} +: 4]} + {1'b0, b_r[{idx, 2'b00} +: 4]} + {4'b0, carry_r};
   assign in_ready  = state == IDLE;
   assign out_valid = state == DONE;
   assign busy      = state != IDLE;
   always_comb begin
      state_d = state;
      case (state)
         IDLE:    state_d = in_valid ? RUN : IDLE;
         RUN:     state_d = last ? DONE : RUN;
         DONE:    state_d = out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         a_r     <= '0;
         b_r     <= '0;
         carry_r <= 1'b0;
         idx     <= '0;
         sum     <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         state <= state_d;
         if (accept) begin
            a_r     <= a;
            b_r     <= do_sub ? ~b : b;
            carry_r <= do_sub | cin;
            idx     <= '0;
            sum     <= '0;
         end else if (state == RUN) begin
            sum[{idx, 2'b00} +: 4] <= slice[3:0];
            carry_r                <= slice[4];
            idx                    <= last ? '0 : idx + 1'b1;
            if (last) begin
               cout <= slice[4];
               ovf  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (slice[3] != a_r[WIDTH-1]);
            end
         end
      end
   end
endmodule

// File: tb/tb_rca_nibble_seq.sv
// tb_rca_nibble_seq: randomized and directed checks of rca_nibble_seq against an arithmetic model.
module tb_rca_nibble_seq;
`ifdef ADD_SUB_EN
   localparam bit SUB = 1'b1;
`else
   localparam bit SUB = 1'b0;
`endif
   logic        clk, rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, busy;
   logic [31:0] a, b, sum;
   int total = 0, bad = 0;

   rca_nibble_seq #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
      .cout(cout), .ovf(ovf), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void ref_model(input logic [31:0] x, y, input logic c, s,
                                     output logic [31:0] r, output logic co, ov);
      logic [32:0] w;
      longint      sr;
      if (s && SUB) begin
         w  = {1'b0, x} - {1'b0, y};
         co = x >= y;
         sr = longint'($signed(x)) - longint'($signed(y));
      end else begin
         w  = {1'b0, x} + {1'b0, y} + 33'(c);
         co = w[32];
         sr = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
      end
      r  = w[31:0];
      ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
   endfunction

   // Called at a negedge in IDLE; returns at a negedge back in IDLE.
   task automatic run_op(input logic [31:0] ta, tbv, input logic tc, ts, output int lat,
                         output logic [31:0] rs, output logic rc, ro, output logic rdy_err);
      a = ta; b = tbv; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      lat = 1;
      rdy_err = 1'b0;
      while (!out_valid && lat < 40) begin
         rdy_err  = rdy_err | in_ready;
         a        = $urandom;
         b        = $urandom;
         cin      = 1'($urandom_range(0, 1));
         sub      = 1'($urandom_range(0, 1));
         in_valid = 1'($urandom_range(0, 1));
         @(negedge clk);
         lat++;
      end
      rdy_err = rdy_err | in_ready;
      in_valid = 1'b0;
      rs = sum; rc = cout; ro = ovf;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (sum !== 32'h0) begin bad++; $display("FAIL reset_sum: got %h want 0", sum); end
      total++; if ({cout, ovf} !== 2'b00) begin bad++; $display("FAIL reset_cout_ovf: got %b want 00", {cout, ovf}); end
      rst_n = 1'b1;
      @(negedge clk);
      total++; if ({in_ready, busy} !== 2'b10) begin bad++; $display("FAIL post_reset_idle: got %b want 10", {in_ready, busy}); end
   endtask

   task automatic test_vectors;
      logic [31:0] va[5] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h0000000F, 32'h5, 32'h80000000};
      logic [31:0] vb[5] = '{32'h0, 32'h1, 32'h1, 32'h7, 32'h1};
      logic        vc[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic        vs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      int lat; logic [31:0] rs, es; logic rc, ro, ec, eo, re;
      for (int i = 0; i < 5; i++) begin
         ref_model(va[i], vb[i], vc[i], vs[i], es, ec, eo);
         run_op(va[i], vb[i], vc[i], vs[i], lat, rs, rc, ro, re);
         total++; if (rs !== es) begin bad++; $display("FAIL vec%0d_sum: got %h want %h", i, rs, es); end
         total++; if ({rc, ro} !== {ec, eo}) begin bad++; $display("FAIL vec%0d_cout_ovf: got %b want %b", i, {rc, ro}, {ec, eo}); end
         total++; if (lat !== 9) begin bad++; $display("FAIL vec%0d_latency: got %0d want 9", i, lat); end
         total++; if (re !== 1'b0) begin bad++; $display("FAIL vec%0d_in_ready_busy: got %b want 0", i, re); end
      end
   endtask

   task automatic test_random;
      int lat; logic [31:0] ta, tbv, rs, es; logic tc, ts, rc, ro, ec, eo, re;
      for (int i = 0; i < 24; i++) begin
         ta = $urandom; tbv = $urandom;
         tc = 1'($urandom_range(0, 1)); ts = 1'($urandom_range(0, 1));
         if (i % 6 == 0) tbv = ta;
         ref_model(ta, tbv, tc, ts, es, ec, eo);
         run_op(ta, tbv, tc, ts, lat, rs, rc, ro, re);
         total++; if ({rs, rc, ro, re} !== {es, ec, eo, 1'b0} || lat !== 9) begin
            bad++;
            $display("FAIL rand%0d: got sum=%h c=%b v=%b rdy=%b lat=%0d want sum=%h c=%b v=%b rdy=0 lat=9",
                     i, rs, rc, ro, re, lat, es, ec, eo);
         end
      end
   endtask

   task automatic test_back_to_back;
      int lat; logic [31:0] rs, es; logic rc, ro, ec, eo, re;
      run_op(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, lat, rs, rc, ro, re);
      total++; if ({in_ready, busy} !== 2'b10) begin bad++; $display("FAIL b2b_idle_at_n_plus_2: got %b want 10", {in_ready, busy}); end
      ref_model(32'hDEADBEEF, 32'h21524111, 1'b1, 1'b0, es, ec, eo);
      run_op(32'hDEADBEEF, 32'h21524111, 1'b1, 1'b0, lat, rs, rc, ro, re);
      total++; if ({rs, rc, ro} !== {es, ec, eo} || lat !== 9) begin
         bad++; $display("FAIL b2b_second: got %h %b%b lat=%0d want %h %b%b lat=9", rs, rc, ro, lat, es, ec, eo);
      end
   endtask

   task automatic test_backpressure;
      int lat; logic [31:0] ta, tbv, es; logic ec, eo, err;
      ta = $urandom; tbv = $urandom;
      ref_model(ta, tbv, 1'b1, 1'b0, es, ec, eo);
      a = ta; b = tbv; cin = 1'b1; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      total++; if (lat !== 9) begin bad++; $display("FAIL bp_latency: got %0d want 9", lat); end
      err = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'($urandom_range(0, 1)); a = $urandom; b = $urandom; out_ready = 1'b0;
         @(negedge clk);
         if ({out_valid, in_ready, busy} !== 3'b101 || sum !== es || {cout, ovf} !== {ec, eo}) err = 1'b1;
      end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL bp_hold: got sum=%h c=%b v=%b ov=%b want sum=%h c=%b v=%b ov=1", sum, cout, ovf, out_valid, es, ec, eo); end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL bp_release: got %b want 01", {out_valid, in_ready}); end
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_single_handshake: got busy=%b want 0", busy); end
   endtask

   task automatic test_reset_mid_run;
      int lat; logic [31:0] rs; logic rc, ro, re, seen;
      a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++; if ({in_ready, out_valid, busy} !== 3'b100) begin bad++; $display("FAIL midrun_reset_flags: got %b want 100", {in_ready, out_valid, busy}); end
      total++; if ({sum, cout, ovf} !== 34'h0) begin bad++; $display("FAIL midrun_reset_data: got %h %b%b want 0 00", sum, cout, ovf); end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         seen = seen | out_valid | busy;
      end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrun_no_out_valid: got %b want 0", seen); end
      run_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, lat, rs, rc, ro, re);
      total++; if (rs !== 32'h23456789 || lat !== 9) begin bad++; $display("FAIL after_reset_op: got %h lat=%0d want 23456789 lat=9", rs, lat); end
   endtask

   initial begin
      test_reset;
      test_vectors;
      test_random;
      test_back_to_back;
      test_backpressure;
      test_reset_mid_run;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
